shift_sequencer: RTL and testbench

- Multi-cycle controller for register-specified shifts (shift amount taken from the bottom byte of Rs, 0-255) in the ARM execute path.
- Sits beside the single-cycle immediate shifter.
- Decode issues a start pulse; the block stalls the pipeline via busy and iterates one bit position per cycle.
- It returns shiftedData plus the ARM shifter carry-out, using ARM semantics for amounts of 32 and above.

---
 rtl/shift_sequencer.sv | 114 +++++++++++
 tb/tb_shift_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle register-specified ARM shifter, one bit position per cycle
module shift_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [1:0]        shiftType,
  input  logic [7:0]        shiftAmt,
  input  logic [DATA_W-1:0] rmData,
  input  logic              carryIn,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] shiftedData,
  output logic              carryOut
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] d_reg, step_d;
  logic              c_reg, step_c;
  logic [CNT_W-1:0]  cnt, n_cnt;
  logic [1:0]        type_reg;
  logic [7:0]        amt_cap;
  logic              accept;

  assign accept = (state == IDLE) && start && !flush;

  // Capping the iteration count is what yields the ARM results for amounts >= 32
  always_comb begin
    amt_cap = shiftAmt;
    case (shiftType)
      2'b00, 2'b01: amt_cap = (shiftAmt > 8'd33) ? 8'd33 : shiftAmt;
      2'b10:        amt_cap = (shiftAmt > 8'd32) ? 8'd32 : shiftAmt;
      default: begin
        if (shiftAmt == 8'd0)             amt_cap = 8'd0;
        else if (shiftAmt[4:0] == 5'd0)   amt_cap = 8'd32;
        else                              amt_cap = {3'b000, shiftAmt[4:0]};
      end
    endcase
    n_cnt = amt_cap[CNT_W-1:0];
  end

  always_comb begin
    step_d = d_reg;
    step_c = c_reg;
    case (type_reg)
      2'b00: begin step_c = d_reg[DATA_W-1]; step_d = {d_reg[DATA_W-2:0], 1'b0}; end
      2'b01: begin step_c = d_reg[0];        step_d = {1'b0, d_reg[DATA_W-1:1]}; end
      2'b10: begin step_c = d_reg[0];        step_d = {d_reg[DATA_W-1], d_reg[DATA_W-1:1]}; end
      default: begin step_c = d_reg[0];      step_d = {d_reg[0], d_reg[DATA_W-1:1]}; end
    endcase
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = (n_cnt != '0) ? SHIFT : DONE;
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      d_reg       <= '0;
      c_reg       <= 1'b0;
      cnt         <= '0;
      type_reg    <= 2'b00;
      shiftedData <= '0;
      carryOut    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          d_reg    <= rmData;
          c_reg    <= carryIn;
          cnt      <= n_cnt;
          type_reg <= shiftType;
          if (n_cnt == '0) begin
            shiftedData <= rmData;
            carryOut    <= carryIn;
          end
        end
        SHIFT: if (!flush) begin
          d_reg <= step_d;
          c_reg <= step_c;
          cnt   <= cnt - CNT_W'(1);
          // Result registers change only on the edge that enters DONE
          if (cnt == CNT_W'(1)) begin
            shiftedData <= step_d;
            carryOut    <= step_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed-vector bench for shift_sequencer
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  shiftType = 2'b00;
  logic [7:0]  shiftAmt = 8'd0;
  logic [31:0] rmData = 32'd0;
  logic        carryIn = 1'b0;
  logic        busy, done, carryOut;
  logic [31:0] shiftedData;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .shiftType(shiftType), .shiftAmt(shiftAmt), .rmData(rmData), .carryIn(carryIn),
    .busy(busy), .done(done), .shiftedData(shiftedData), .carryOut(carryOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] st, input logic [7:0] amt,
                        input logic [31:0] data, input logic cin,
                        input logic [31:0] exp_d, input logic exp_c,
                        input int exp_lat, input bit poke);
    int lat, bcnt;
    @(negedge clk);
    shiftType = st; shiftAmt = amt; rmData = data; carryIn = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    shiftType = ~st; shiftAmt = ~amt; rmData = ~data; carryIn = ~cin;
    lat  = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      if (poke && lat == 1) begin
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      lat++;
      if (busy) bcnt++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, shiftedData, exp_d);
    check({tag, "_carry"}, {31'd0, carryOut}, {31'd0, exp_c});
    check({tag, "_busycyc"}, bcnt, exp_lat - 1);
    @(posedge clk); #1;
    check({tag, "_donepulse"}, {31'd0, done}, 32'd0);
    check({tag, "_heldata"}, shiftedData, exp_d);
  endtask

  initial begin
    int seen;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", shiftedData, 32'd0);
    check("rst_carry", {31'd0, carryOut}, 32'd0);
    @(negedge clk); reset = 1'b1;

    run_op("lsl4",    2'b00, 8'd4,   32'h0000_0001, 1'b1, 32'h0000_0010, 1'b0, 5,  1'b0);
    run_op("lsr32",   2'b01, 8'd32,  32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1, 33, 1'b0);
    run_op("lsr40",   2'b01, 8'd40,  32'h8000_0001, 1'b1, 32'h0000_0000, 1'b0, 34, 1'b0);
    run_op("asr200",  2'b10, 8'd200, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 33, 1'b0);
    run_op("ror4",    2'b11, 8'd4,   32'h0000_00F1, 1'b1, 32'h1000_000F, 1'b0, 5,  1'b0);
    run_op("ror32",   2'b11, 8'd32,  32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 33, 1'b0);
    run_op("ror36",   2'b11, 8'd36,  32'h0000_00F1, 1'b1, 32'h1000_000F, 1'b0, 5,  1'b0);
    run_op("ror0",    2'b11, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1,  1'b0);
    run_op("lsl0",    2'b00, 8'd0,   32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 1'b1, 1,  1'b0);
    run_op("lsl32",   2'b00, 8'd32,  32'h0000_0003, 1'b0, 32'h0000_0000, 1'b1, 33, 1'b0);
    run_op("lsl33",   2'b00, 8'd33,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 34, 1'b0);
    run_op("busypoke",2'b00, 8'd4,   32'h0000_0001, 1'b1, 32'h0000_0010, 1'b0, 5,  1'b1);

    // flush mid-shift: previous result 0x10/C=0 must survive
    @(negedge clk);
    shiftType = 2'b00; shiftAmt = 8'd20; rmData = 32'hDEAD_BEEF; carryIn = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (done || busy) seen++; end
    check("flush_nodone", seen, 0);
    check("flush_data", shiftedData, 32'h0000_0010);
    check("flush_carry", {31'd0, carryOut}, 32'd0);

    // flush and start together in IDLE drop the request
    @(negedge clk);
    shiftType = 2'b01; shiftAmt = 8'd3; rmData = 32'h0000_00FF; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (6) begin if (done || busy) seen++; @(posedge clk); #1; end
    check("flushstart_noop", seen, 0);
    check("flushstart_data", shiftedData, 32'h0000_0010);

    // asynchronous reset in the middle of a shift
    @(negedge clk);
    shiftType = 2'b00; shiftAmt = 8'd20; rmData = 32'h0000_0001; carryIn = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_data", shiftedData, 32'd0);
    check("arst_carry", {31'd0, carryOut}, 32'd0);
    @(negedge clk); reset = 1'b1;
    run_op("postrst", 2'b10, 8'd4, 32'hF000_0008, 1'b0, 32'hFF00_0000, 1'b1, 5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
